// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing: registered pixel counters, sync/blank qualifiers,
// a frame-start pulse and sync copies delayed to match the colour pipeline.
module vga_timing_gen #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int PIPE_DELAY = 2
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       frame_start,
    output logic       hs_d,
    output logic       vs_d,
    output logic       blank_d
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_MAX        = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX        = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACTIVE     = 10'(H_VISIBLE);
    localparam logic [9:0] V_ACTIVE     = 10'(V_VISIBLE);
    localparam logic [9:0] H_SYNC_FIRST = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_SYNC_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] V_SYNC_FIRST = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_SYNC_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic       h_wrap;
    logic       v_wrap;
    logic [9:0] hc_nxt;
    logic [9:0] vc_nxt;

    always_comb begin
        h_wrap = (DrawX == H_MAX);
        v_wrap = (DrawY == V_MAX);
        hc_nxt = h_wrap ? 10'd0 : DrawX + 10'd1;
        vc_nxt = DrawY;
        if (h_wrap) begin
            vc_nxt = v_wrap ? 10'd0 : DrawY + 10'd1;
        end
    end

    // Qualifiers are decoded from the next counter values so that, once
    // registered, they describe the DrawX/DrawY presented in the same cycle.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            DrawX       <= 10'd0;
            DrawY       <= 10'd0;
            hs          <= 1'b1;
            vs          <= 1'b1;
            blank       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            DrawX       <= hc_nxt;
            DrawY       <= vc_nxt;
            hs          <= !((hc_nxt >= H_SYNC_FIRST) && (hc_nxt <= H_SYNC_LAST));
            vs          <= !((vc_nxt >= V_SYNC_FIRST) && (vc_nxt <= V_SYNC_LAST));
            blank       <= (hc_nxt < H_ACTIVE) && (vc_nxt < V_ACTIVE);
            frame_start <= h_wrap && v_wrap;
        end
    end

    generate
        if (PIPE_DELAY == 0) begin : g_no_delay
            assign hs_d    = hs;
            assign vs_d    = vs;
            assign blank_d = blank;
        end else begin : g_delay
            logic [PIPE_DELAY-1:0] hs_pipe;
            logic [PIPE_DELAY-1:0] vs_pipe;
            logic [PIPE_DELAY-1:0] blank_pipe;

            // Stages reset to the idle level so the DAC sees no sync pulse
            // or active video while the pipe refills after reset.
            always_ff @(posedge vga_clk or negedge reset_n) begin
                if (!reset_n) begin
                    hs_pipe    <= '1;
                    vs_pipe    <= '1;
                    blank_pipe <= '0;
                end else begin
                    hs_pipe[0]    <= hs;
                    vs_pipe[0]    <= vs;
                    blank_pipe[0] <= blank;
                    for (int i = 1; i < PIPE_DELAY; i++) begin
                        hs_pipe[i]    <= hs_pipe[i-1];
                        vs_pipe[i]    <= vs_pipe[i-1];
                        blank_pipe[i] <= blank_pipe[i-1];
                    end
                end
            end

            assign hs_d    = hs_pipe[PIPE_DELAY-1];
            assign vs_d    = vs_pipe[PIPE_DELAY-1];
            assign blank_d = blank_pipe[PIPE_DELAY-1];
        end
    endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size instance for line timing and the 2-cycle delay line,
// a reduced-raster instance (16x12, no delay) for frame-level behaviour.
module tb_vga_timing_gen;

    logic vga_clk = 1'b0;
    always #20 vga_clk = ~vga_clk;

    logic rst_a;
    logic rst_b;

    logic [9:0] a_x, a_y;
    logic       a_blank, a_hs, a_vs, a_fs, a_hs_d, a_vs_d, a_blank_d;
    logic [9:0] b_x, b_y;
    logic       b_blank, b_hs, b_vs, b_fs, b_hs_d, b_vs_d, b_blank_d;

    vga_timing_gen #(.PIPE_DELAY(2)) dut_a (
        .vga_clk(vga_clk), .reset_n(rst_a),
        .DrawX(a_x), .DrawY(a_y), .blank(a_blank), .hs(a_hs), .vs(a_vs),
        .frame_start(a_fs), .hs_d(a_hs_d), .vs_d(a_vs_d), .blank_d(a_blank_d)
    );

    // Small raster: H 8+2+3+3 = 16, V 6+2+2+2 = 12, frame = 192 cycles.
    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2),
        .PIPE_DELAY(0)
    ) dut_b (
        .vga_clk(vga_clk), .reset_n(rst_b),
        .DrawX(b_x), .DrawY(b_y), .blank(b_blank), .hs(b_hs), .vs(b_vs),
        .frame_start(b_fs), .hs_d(b_hs_d), .vs_d(b_vs_d), .blank_d(b_blank_d)
    );

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    int prev_hs, prev_hsd, prev_vs, prev_x, prev_y;
    int hs_fall_x, hs_rise_x, hs_low, hs_falls, hsd_fall_x;
    int y_steps, y_bad, blank_640, blank_639, fs_a;
    int k, pos_bad, fs_cnt, fs_k1, fs_k2, fs_bad, vs_low;
    int vs_fall_x, vs_fall_y, vs_end_x, vs_end_y, blank_cnt, d_bad;
    int bl_8_0, bl_0_6, bl_15_11, bl_7_5;
    int wait_cnt, seq_bad, glitch;

    initial begin
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge vga_clk);
        chk("a_rst_x", int'(a_x), 0);
        chk("a_rst_y", int'(a_y), 0);
        chk("a_rst_hs", int'(a_hs), 1);
        chk("a_rst_vs", int'(a_vs), 1);
        chk("a_rst_blank", int'(a_blank), 1);
        chk("a_rst_fs", int'(a_fs), 0);
        chk("a_rst_hs_d", int'(a_hs_d), 1);
        chk("a_rst_vs_d", int'(a_vs_d), 1);
        chk("a_rst_blank_d", int'(a_blank_d), 0);
        chk("b_rst_blank_d", int'(b_blank_d), 1);

        // Full-size instance: first edge, then two complete lines.
        rst_a = 1'b1;
        @(negedge vga_clk);
        chk("a_first_x", int'(a_x), 1);
        chk("a_first_y", int'(a_y), 0);

        prev_hs = int'(a_hs); prev_hsd = int'(a_hs_d);
        prev_x = int'(a_x); prev_y = int'(a_y);
        hs_fall_x = -1; hs_rise_x = -1; hsd_fall_x = -1;
        hs_low = 0; hs_falls = 0; y_steps = 0; y_bad = 0; fs_a = 0;
        blank_640 = -1; blank_639 = -1;
        for (int i = 0; i < 1600; i++) begin
            @(negedge vga_clk);
            if (prev_hs == 1 && a_hs == 1'b0) begin
                hs_falls++;
                if (hs_fall_x < 0) hs_fall_x = int'(a_x);
            end
            if (prev_hs == 0 && a_hs == 1'b1 && hs_rise_x < 0) hs_rise_x = int'(a_x);
            if (a_hs == 1'b0) hs_low++;
            if (prev_hsd == 1 && a_hs_d == 1'b0 && hsd_fall_x < 0) hsd_fall_x = int'(a_x);
            if (int'(a_y) != prev_y) begin
                y_steps++;
                if (!(prev_x == 799 && a_x == 10'd0 && int'(a_y) == prev_y + 1)) y_bad++;
            end
            if (a_x == 10'd640 && a_y == 10'd0) blank_640 = int'(a_blank);
            if (a_x == 10'd639 && a_y == 10'd0) blank_639 = int'(a_blank);
            if (a_fs) fs_a++;
            prev_hs = int'(a_hs); prev_hsd = int'(a_hs_d);
            prev_x = int'(a_x); prev_y = int'(a_y);
        end
        chk("hs_fall_x", hs_fall_x, 656);
        chk("hs_rise_x", hs_rise_x, 752);
        chk("hs_low_2lines", hs_low, 192);
        chk("hs_falls", hs_falls, 2);
        chk("hs_d_fall_x", hsd_fall_x, 658);
        chk("y_steps", y_steps, 2);
        chk("y_step_bad", y_bad, 0);
        chk("blank_640_0", blank_640, 0);
        chk("blank_639_0", blank_639, 1);
        chk("a_no_fs", fs_a, 0);
        chk("a_after_x", int'(a_x), 1);
        chk("a_after_y", int'(a_y), 2);

        // Asynchronous reset in the middle of a visible line.
        repeat (300) @(negedge vga_clk);
        chk("a_mid_x_before", int'(a_x), 301);
        rst_a = 1'b0;
        #1;
        chk("a_mid_rst_x", int'(a_x), 0);
        chk("a_mid_rst_y", int'(a_y), 0);
        chk("a_mid_rst_blank", int'(a_blank), 1);
        chk("a_mid_rst_blank_d", int'(a_blank_d), 0);
        chk("a_mid_rst_hs_d", int'(a_hs_d), 1);

        // Small instance: two frames plus a little.
        @(negedge vga_clk);
        rst_b = 1'b1;
        pos_bad = 0; fs_cnt = 0; fs_k1 = -1; fs_k2 = -1; fs_bad = 0;
        vs_low = 0; vs_fall_x = -1; vs_fall_y = -1; vs_end_x = -1; vs_end_y = -1;
        blank_cnt = 0; d_bad = 0;
        bl_8_0 = -1; bl_0_6 = -1; bl_15_11 = -1; bl_7_5 = -1;
        prev_vs = int'(b_vs); prev_x = int'(b_x); prev_y = int'(b_y);
        for (k = 1; k <= 400; k++) begin
            @(negedge vga_clk);
            if (int'(b_x) != k % 16 || int'(b_y) != (k / 16) % 12) pos_bad++;
            if (b_fs) begin
                fs_cnt++;
                if (fs_k1 < 0) fs_k1 = k;
                else if (fs_k2 < 0) fs_k2 = k;
                if (b_x != 10'd0 || b_y != 10'd0) fs_bad++;
            end
            if (b_vs == 1'b0) vs_low++;
            if (prev_vs == 1 && b_vs == 1'b0 && vs_fall_x < 0) begin
                vs_fall_x = int'(b_x); vs_fall_y = int'(b_y);
            end
            if (prev_vs == 0 && b_vs == 1'b1 && vs_end_x < 0) begin
                vs_end_x = prev_x; vs_end_y = prev_y;
            end
            if (k >= 192 && k < 384 && b_blank) blank_cnt++;
            if (b_hs_d !== b_hs || b_vs_d !== b_vs || b_blank_d !== b_blank) d_bad++;
            if (k < 192) begin
                if (b_x == 10'd8 && b_y == 10'd0) bl_8_0 = int'(b_blank);
                if (b_x == 10'd0 && b_y == 10'd6) bl_0_6 = int'(b_blank);
                if (b_x == 10'd15 && b_y == 10'd11) bl_15_11 = int'(b_blank);
                if (b_x == 10'd7 && b_y == 10'd5) bl_7_5 = int'(b_blank);
            end
            prev_vs = int'(b_vs); prev_x = int'(b_x); prev_y = int'(b_y);
        end
        chk("b_pos_seq", pos_bad, 0);
        chk("b_fs_count", fs_cnt, 2);
        chk("b_fs_first_k", fs_k1, 192);
        chk("b_fs_second_k", fs_k2, 384);
        chk("b_fs_pos", fs_bad, 0);
        chk("b_vs_low", vs_low, 64);
        chk("b_vs_fall_x", vs_fall_x, 0);
        chk("b_vs_fall_y", vs_fall_y, 8);
        chk("b_vs_end_x", vs_end_x, 15);
        chk("b_vs_end_y", vs_end_y, 9);
        chk("b_blank_count", blank_cnt, 48);
        chk("b_delay0_equal", d_bad, 0);
        chk("b_blank_8_0", bl_8_0, 0);
        chk("b_blank_0_6", bl_0_6, 0);
        chk("b_blank_15_11", bl_15_11, 0);
        chk("b_blank_7_5", bl_7_5, 1);

        // Reach a point inside the hsync pulse, then reset asynchronously.
        wait_cnt = 0;
        while (!(b_x == 10'd12 && b_y == 10'd3) && wait_cnt < 300) begin
            @(negedge vga_clk);
            wait_cnt++;
        end
        chk("b_reach_12_3", int'(b_x == 10'd12 && b_y == 10'd3), 1);
        chk("b_hs_before_rst", int'(b_hs), 0);
        rst_b = 1'b0;
        #1;
        chk("b_mid_rst_x", int'(b_x), 0);
        chk("b_mid_rst_y", int'(b_y), 0);
        chk("b_mid_rst_hs", int'(b_hs), 1);
        chk("b_mid_rst_vs", int'(b_vs), 1);
        chk("b_mid_rst_blank", int'(b_blank), 1);
        chk("b_mid_rst_fs", int'(b_fs), 0);

        @(negedge vga_clk);
        rst_b = 1'b1;
        seq_bad = 0; glitch = 0;
        for (k = 1; k <= 9; k++) begin
            @(negedge vga_clk);
            if (int'(b_x) != k || b_y != 10'd0) seq_bad++;
            if (b_hs !== 1'b1 || b_vs !== 1'b1) glitch++;
        end
        chk("b_release_seq", seq_bad, 0);
        chk("b_release_glitch", glitch, 0);
        k = 9;
        while (!b_fs && k < 400) begin
            @(negedge vga_clk);
            k++;
        end
        chk("b_fs_after_release", k, 192);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
